// File: rtl/fp_align_stage.sv
// FP16 add/sub operand-alignment front end: unpack, magnitude-order, align the smaller
// significand and present adder operands plus GRS/exponent/sign/special flags over two stages.
module fp_align_stage #(
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10,
  parameter int SH_SAT = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAN_W:0]         add_a,
  output logic [MAN_W:0]         add_b,
  output logic                   add_cin,
  output logic [2:0]             grs,
  output logic [EXP_W-1:0]       exp_out,
  output logic                   sign_out,
  output logic                   eff_sub,
  output logic                   is_nan,
  output logic                   is_inf
);

  localparam int SIG_W = MAN_W + 1;
  localparam int D_W   = $clog2(SH_SAT + 1);
  localparam int EXT_W = SIG_W + SH_SAT;
  localparam int MAG_W = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] SAT_EXP  = EXP_W'(SH_SAT);
  localparam logic [D_W-1:0]   SAT_D    = D_W'(SH_SAT);

  // Unpacked operand fields
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             sign_a, sign_b_eff;

  assign exp_a      = op_a[MAG_W-1:MAN_W];
  assign exp_b      = op_b[MAG_W-1:MAN_W];
  assign frac_a     = op_a[MAN_W-1:0];
  assign frac_b     = op_b[MAN_W-1:0];
  assign sign_a     = op_a[MAG_W];
  assign sign_b_eff = op_b[MAG_W] ^ sub;

  // Stage-1 combinational classification / ordering
  logic             swap, mag_eq, eff_sub_c;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0] big_exp, small_exp, big_eexp, small_eexp, diff;
  logic [MAN_W-1:0] big_frac, small_frac;
  logic [SIG_W-1:0] big_sig, small_sig;
  logic [D_W-1:0]   d_sat;
  logic             sign_c, nan_c, inf_c;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    swap       = 1'b0;
    mag_eq     = 1'b0;
    big_exp    = exp_a;
    big_frac   = frac_a;
    small_exp  = exp_b;
    small_frac = frac_b;
    sign_c     = sign_a;

    eff_sub_c = sign_a ^ sign_b_eff;
    swap      = op_b[MAG_W-1:0] > op_a[MAG_W-1:0];
    mag_eq    = op_b[MAG_W-1:0] == op_a[MAG_W-1:0];
    if (swap) begin
      big_exp    = exp_b;
      big_frac   = frac_b;
      small_exp  = exp_a;
      small_frac = frac_a;
      sign_c     = sign_b_eff;
    end
    if (mag_eq && eff_sub_c) sign_c = 1'b0;

    // Subnormals (exp==0) carry no hidden bit and behave as exponent 1.
    big_sig    = {(big_exp != '0), big_frac};
    small_sig  = {(small_exp != '0), small_frac};
    big_eexp   = (big_exp == '0) ? EXP_W'(1) : big_exp;
    small_eexp = (small_exp == '0) ? EXP_W'(1) : small_exp;
    diff       = big_eexp - small_eexp;
    d_sat      = (diff >= SAT_EXP) ? SAT_D : diff[D_W-1:0];

    nan_a = (exp_a == EXP_MAX) && (frac_a != '0);
    nan_b = (exp_b == EXP_MAX) && (frac_b != '0);
    inf_a = (exp_a == EXP_MAX) && (frac_a == '0);
    inf_b = (exp_b == EXP_MAX) && (frac_b == '0);
    nan_c = nan_a || nan_b || (inf_a && inf_b && eff_sub_c);
    inf_c = (inf_a || inf_b) && !nan_c;
  end

  // Handshake: each stage holds when the next stage is full and not draining.
  logic s1_valid, s2_valid;
  logic s2_ready, s1_adv, in_fire;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  logic [SIG_W-1:0] s1_big_sig, s1_small_sig;
  logic [EXP_W-1:0] s1_exp;
  logic [D_W-1:0]   s1_d;
  logic             s1_sign, s1_eff_sub, s1_nan, s1_inf;

  // NOTE: stage-1 payload is deliberately not reset; it is only observed when
  // s1_valid is set, and s1_valid is cleared by reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_big_sig   <= big_sig;
      s1_small_sig <= small_sig;
      s1_exp       <= big_eexp;
      s1_d         <= d_sat;
      s1_sign      <= sign_c;
      s1_eff_sub   <= eff_sub_c;
      s1_nan       <= nan_c;
      s1_inf       <= inf_c;
    end
  end

  // Stage-2 combinational alignment
  logic [EXT_W-1:0] ext;
  logic [SIG_W-1:0] aligned;
  logic             g_bit, r_bit, s_bit;

  always_comb begin
    ext     = {s1_small_sig, {SH_SAT{1'b0}}} >> s1_d;
    aligned = ext[EXT_W-1:SH_SAT];
    g_bit   = ext[SH_SAT-1];
    r_bit   = ext[SH_SAT-2];
    s_bit   = |ext[SH_SAT-3:0];
    if (s1_d == SAT_D) begin
      aligned = '0;
      g_bit   = 1'b0;
      r_bit   = 1'b0;
      s_bit   = |s1_small_sig;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      grs      <= '0;
      exp_out  <= '0;
      sign_out <= 1'b0;
      eff_sub  <= 1'b0;
      is_nan   <= 1'b0;
      is_inf   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_adv) begin
        add_a    <= s1_big_sig;
        add_b    <= s1_eff_sub ? ~aligned : aligned;
        add_cin  <= s1_eff_sub;
        grs      <= {g_bit, r_bit, s_bit};
        exp_out  <= s1_exp;
        sign_out <= s1_sign;
        eff_sub  <= s1_eff_sub;
        is_nan   <= s1_nan;
        is_inf   <= s1_inf;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed cases plus randomized traffic
// scored against an arithmetic reference model of the alignment rules.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] add_a, add_b;
  logic        add_cin;
  logic [2:0]  grs;
  logic [4:0]  exp_out;
  logic        sign_out, eff_sub, is_nan, is_inf;

  fp_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .grs(grs), .exp_out(exp_out),
    .sign_out(sign_out), .eff_sub(eff_sub), .is_nan(is_nan), .is_inf(is_inf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] a;
    logic [10:0] b;
    logic        cin;
    logic [2:0]  grs;
    logic [4:0]  e;
    logic        sign;
    logic        es;
    logic        nan;
    logic        inf;
  } res_t;

  res_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          out_cyc = 0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b1;
  logic        drv_sub = 1'b0;
  logic [15:0] drv_a = '0;
  logic [15:0] drv_b = '0;
  logic        in_fire = 1'b0;
  logic        out_fire = 1'b0;
  logic        stalled = 1'b0;
  res_t        stall_val;
  res_t        last_got;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the binary16 fields.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    res_t r;
    int ea, eb, fa, fb, ma, mb, be, bf, se, sf, bsig, ssig, d, al, g, rb, st;
    bit sa, sb, eff, nan_a, nan_b, inf_a, inf_b;
    ea = int'(a[14:10]); fa = int'(a[9:0]);
    eb = int'(b[14:10]); fb = int'(b[9:0]);
    sa = a[15];
    sb = b[15] ^ s;
    eff = (sa != sb);
    ma = ea * 1024 + fa;
    mb = eb * 1024 + fb;
    if (mb > ma) begin
      be = eb; bf = fb; se = ea; sf = fa; r.sign = sb;
    end else begin
      be = ea; bf = fa; se = eb; sf = fb; r.sign = sa;
    end
    if (ma == mb && eff) r.sign = 1'b0;
    bsig = (be == 0) ? bf : bf + 1024;
    ssig = (se == 0) ? sf : sf + 1024;
    if (be == 0) be = 1;
    if (se == 0) se = 1;
    d  = be - se;
    al = ssig >> d;
    g  = (d >= 1) ? ((ssig >> (d - 1)) & 1) : 0;
    rb = (d >= 2) ? ((ssig >> (d - 2)) & 1) : 0;
    st = (d >= 3) ? (((ssig & ((1 << (d - 2)) - 1)) != 0) ? 1 : 0) : 0;
    r.a   = 11'(bsig);
    r.b   = eff ? 11'(2047 - al) : 11'(al);
    r.cin = eff;
    r.grs = 3'(g * 4 + rb * 2 + st);
    r.e   = 5'(be);
    r.es  = eff;
    nan_a = (ea == 31) && (fa != 0);
    nan_b = (eb == 31) && (fb != 0);
    inf_a = (ea == 31) && (fa == 0);
    inf_b = (eb == 31) && (fb == 0);
    r.nan = nan_a || nan_b || (inf_a && inf_b && eff);
    r.inf = (inf_a || inf_b) && !r.nan;
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.a = add_a; r.b = add_b; r.cin = add_cin; r.grs = grs; r.e = exp_out;
    r.sign = sign_out; r.es = eff_sub; r.nan = is_nan; r.inf = is_inf;
    return r;
  endfunction

  // One clock: drive at negedge, evaluate handshakes just after, score outputs.
  task automatic cycle();
    res_t cur;
    @(negedge clk);
    cyc++;
    in_valid  = drv_valid;
    op_a      = drv_a;
    op_b      = drv_b;
    sub       = drv_sub;
    out_ready = drv_ready;
    #1;
    cur      = sample();
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (stalled) begin
      check("hold valid", 64'(out_valid), 64'(1));
      check("hold data", 64'(cur), 64'(stall_val));
    end
    stalled   = out_valid && !out_ready;
    stall_val = cur;
    if (out_fire) begin
      check("unexpected output", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) check("scoreboard", 64'(cur), 64'(q.pop_front()));
      last_got = cur;
      out_cyc  = cyc;
      n_out++;
    end
    if (in_fire) begin
      q.push_back(model(drv_a, drv_b, drv_sub));
      acc_cyc = cyc;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    drv_a = a; drv_b = b; drv_sub = s; drv_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (in_fire) break;
    end
    check("send accepted", 64'(in_fire), 64'(1));
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) cycle();
    check("drain empty", 64'(q.size()), 64'(0));
  endtask

  task automatic rand_ops();
    logic [4:0] e;
    drv_a   = 16'($urandom);
    drv_sub = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: drv_b = 16'($urandom);
      1: begin
        e = drv_a[14:10] + 5'($urandom_range(0, 4)) - 5'd2;
        drv_b = {1'($urandom_range(0, 1)), e, 10'($urandom)};
      end
      2: drv_b = {1'($urandom_range(0, 1)), 5'd0, 10'($urandom)};
      default: drv_b = drv_a ^ {1'($urandom_range(0, 1)), 15'd0};
    endcase
  endtask

  res_t want;
  int   base;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst data", 64'(sample()), 64'(0));
    rst = 1'b0;

    // 1: 1.0 + 1.0, also measures latency
    send(16'h3C00, 16'h3C00, 1'b0);
    drain();
    want = '{a: 11'h400, b: 11'h400, cin: 1'b0, grs: 3'b000, e: 5'd15,
             sign: 1'b0, es: 1'b0, nan: 1'b0, inf: 1'b0};
    check("t1 result", 64'(last_got), 64'(want));
    check("t1 latency", 64'(out_cyc - acc_cyc), 64'(2));

    // 2: 1.0 - 0.5
    send(16'h3C00, 16'h3800, 1'b1);
    drain();
    want = '{a: 11'h400, b: 11'h5FF, cin: 1'b1, grs: 3'b000, e: 5'd15,
             sign: 1'b0, es: 1'b1, nan: 1'b0, inf: 1'b0};
    check("t2 result", 64'(last_got), 64'(want));

    // 3: 0.5 + 2.0 requires swap
    send(16'h3800, 16'h4000, 1'b0);
    drain();
    want = '{a: 11'h400, b: 11'h100, cin: 1'b0, grs: 3'b000, e: 5'd16,
             sign: 1'b0, es: 1'b0, nan: 1'b0, inf: 1'b0};
    check("t3 result", 64'(last_got), 64'(want));

    // 4: large + smallest subnormal, shift saturates to all-sticky
    send(16'h6400, 16'h0001, 1'b0);
    drain();
    want = '{a: 11'h400, b: 11'h000, cin: 1'b0, grs: 3'b001, e: 5'd25,
             sign: 1'b0, es: 1'b0, nan: 1'b0, inf: 1'b0};
    check("t4 result", 64'(last_got), 64'(want));

    // 5: backpressure with three back-to-back pairs
    base = n_out;
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    drv_a = 16'h4200; drv_b = 16'h3C01; drv_sub = 1'b0;
    cycle();
    check("t5 accept0", 64'(in_fire), 64'(1));
    drv_a = 16'hC500; drv_b = 16'h2E55; drv_sub = 1'b1;
    cycle();
    check("t5 accept1", 64'(in_fire), 64'(1));
    drv_a = 16'h0300; drv_b = 16'h8123; drv_sub = 1'b0;
    cycle();
    check("t5 in_ready low", 64'(in_ready), 64'(0));
    check("t5 out_valid", 64'(out_valid), 64'(1));
    repeat (3) cycle();
    check("t5 still blocked", 64'(in_ready), 64'(0));
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (in_fire) break;
    end
    check("t5 accept2", 64'(in_fire), 64'(1));
    drain();
    check("t5 outputs", 64'(n_out - base), 64'(3));

    // 6: +inf + -inf is NaN
    send(16'h7C00, 16'hFC00, 1'b0);
    drain();
    check("t6 is_nan", 64'(last_got.nan), 64'(1));
    check("t6 is_inf", 64'(last_got.inf), 64'(0));

    // Reset with both stages full discards in-flight pairs
    drv_ready = 1'b0;
    send(16'h4400, 16'h4000, 1'b0);
    send(16'h4800, 16'h3000, 1'b1);
    cycle();
    check("full in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'(0));
    check("mid rst in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    q.delete();
    stalled = 1'b0;
    base = n_out;
    drv_ready = 1'b1;
    send(16'h5000, 16'hD000, 1'b0);
    drain();
    check("post rst outputs", 64'(n_out - base), 64'(1));

    // Randomized traffic with random valid/ready
    for (int k = 0; k < 600; k++) begin
      if (!drv_valid || in_fire) begin
        drv_valid = ($urandom_range(0, 3) != 0);
        if (drv_valid) rand_ops();
      end
      drv_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
